// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle sequencing controller for the LEGv8 datapath.
// Latches each fetched instruction into ir, then walks FETCH/DECODE/EXEC/MEM/WB.
// B, CBZ and CBNZ take 3 cycles. ADD, SUB, AND, ORR and STUR take 4. LDUR takes 5.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to make FETCH and MEM wait for mem_ready.

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef WORD
`define WORD 64
`endif

module multicycle_controller (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [`INSTR_LEN-1:0] instruction,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic [`INSTR_LEN-1:0] ir,
    output logic                  ir_load,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  alu_src,
    output logic                  pc_src,
    output logic [3:0]            alu_op,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [`WORD-1:0]      retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_LDUR, OP_STUR, OP_ADD, OP_SUB, OP_AND, OP_ORR,
        OP_CBZ, OP_CBNZ, OP_B, OP_ILL
    } op_t;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    state_t state, state_next;
    op_t    op;
    logic   mem_ok;
    logic   done;

`ifdef MC_CTRL_MEM_WAIT_EN
    // Memory accesses complete only on the cycle the memory reports ready.
    assign mem_ok = mem_ready;
`else
    // Without the wait option, memory always answers in one cycle.
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    // Classify the latched instruction by its opcode field; wider fields are tried first.
    always_comb begin
        op = OP_ILL;
        case (ir[31:21])
            OPC_LDUR: op = OP_LDUR;
            OPC_STUR: op = OP_STUR;
            OPC_ADD:  op = OP_ADD;
            OPC_SUB:  op = OP_SUB;
            OPC_AND:  op = OP_AND;
            OPC_ORR:  op = OP_ORR;
            default: begin
                if (ir[31:24] == OPC_CBZ)       op = OP_CBZ;
                else if (ir[31:24] == OPC_CBNZ) op = OP_CBNZ;
                else if (ir[31:26] == OPC_B)    op = OP_B;
            end
        endcase
    end

    // Next-state and Moore strobe decode from state, ir and zero.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        done       = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        pc_src     = 1'b0;
        alu_op     = ALU_AND;

        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                // Strobes stay asserted while waiting; ir only captures on the ready cycle.
                mem_read = 1'b1;
                ir_load  = 1'b1;
                pc_write = 1'b1;
                if (mem_ok) state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = (op == OP_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (op)
                    OP_LDUR, OP_STUR: begin
                        alu_src    = 1'b1;
                        alu_op     = ALU_ADD;
                        state_next = S_MEM;
                    end
                    OP_ADD: begin alu_op = ALU_ADD; state_next = S_WB; end
                    OP_SUB: begin alu_op = ALU_SUB; state_next = S_WB; end
                    OP_AND: begin alu_op = ALU_AND; state_next = S_WB; end
                    OP_ORR: begin alu_op = ALU_OR;  state_next = S_WB; end
                    OP_CBZ: begin
                        alu_op   = ALU_PASSB;
                        pc_write = zero;
                        pc_src   = zero;
                        done     = 1'b1;
                    end
                    OP_CBNZ: begin
                        alu_op   = ALU_PASSB;
                        pc_write = ~zero;
                        pc_src   = ~zero;
                        done     = 1'b1;
                    end
                    OP_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        done     = 1'b1;
                    end
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (op == OP_LDUR) begin
                    mem_read = 1'b1;
                    if (mem_ok) state_next = S_WB;
                end else begin
                    mem_write = 1'b1;
                    done      = mem_ok;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op == OP_LDUR);
                done       = 1'b1;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: state_next = S_IDLE;
        endcase

        // run is only looked at on the retiring cycle, so dropping it never aborts an instruction.
        if (done) state_next = run ? S_FETCH : S_IDLE;
    end

    assign instr_done = done;

    // State, instruction register, retire counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir      <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge-sampled values.
            state <= state_next;
            if (state == S_FETCH && mem_ok) ir <= instruction;
            if (done) retired <= retired + {{(`WORD-1){1'b0}}, 1'b1};
            if (state == S_DECODE && op == OP_ILL) illegal <= 1'b1;
        end
    end

endmodule
